// File: rtl/spi_gyro_reader.sv
// Mode-3 SPI master for the gyro. After reset it wakes the IMU once, then on
// each period tick it burst-reads GX/GY/GZ and presents them with a valid strobe.
module spi_gyro_reader #(
    parameter int unsigned CLK_DIV       = 5,
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter logic [7:0]  GYRO_REG      = 8'h43,
    parameter logic [7:0]  PWR_REG       = 8'h6B,
    parameter logic [7:0]  PWR_VAL       = 8'h00
) (
    input  logic        clk_100mhz,
    input  logic        rst_in,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [15:0] gx,
    output logic [15:0] gy,
    output logic [15:0] gz,
    output logic        valid,
    output logic        busy
);
    localparam logic [2:0] ST_INIT_WAIT = 3'd0;
    localparam logic [2:0] ST_CS_SETUP  = 3'd1;
    localparam logic [2:0] ST_SHIFT     = 3'd2;
    localparam logic [2:0] ST_CS_HOLD   = 3'd3;
    localparam logic [2:0] ST_LATCH     = 3'd4;
    localparam logic [2:0] ST_IDLE      = 3'd5;

    localparam int CNT_W = $clog2(2 * CLK_DIV + 16);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(15);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SAMPLE_PERIOD - 1);

    localparam logic [5:0] INIT_BIT_LAST   = 6'd15;
    localparam logic [5:0] SAMPLE_BIT_LAST = 6'd55;

    // Both frames are left-aligned in a 56-bit word; the init frame just stops early.
    localparam logic [55:0] INIT_WORD   = {1'b0, PWR_REG[6:0], PWR_VAL, 40'd0};
    localparam logic [55:0] SAMPLE_WORD = {1'b1, GYRO_REG[6:0], 48'd0};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_q, bit_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [54:0]      tx_q, tx_d;
    logic [47:0]      rx_q, rx_d;
    logic             init_done_q, init_done_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic [15:0]      gx_q, gx_d;
    logic [15:0]      gy_q, gy_d;
    logic [15:0]      gz_q, gz_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             start_frame;
    logic [5:0]       bit_last;
    logic [55:0]      frame_word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        init_done_d = init_done_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        gz_d        = gz_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        start_frame = 1'b0;

        tick       = (timer_q == TMR_LAST);
        timer_d    = tick ? '0 : timer_q + TMR_W'(1);
        bit_last   = init_done_q ? SAMPLE_BIT_LAST : INIT_BIT_LAST;
        frame_word = init_done_q ? SAMPLE_WORD : INIT_WORD;

        case (state_q)
            ST_INIT_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WAIT_LAST) begin
                    start_frame = 1'b1;
                end
            end
            ST_CS_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                // miso is captured on the same clk edge that raises sclk
                if (cnt_q == HALF_LAST) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[46:0], miso};
                end
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == bit_last) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                        mosi_d = tx_q[54];
                        tx_d   = {tx_q[53:0], 1'b0};
                    end
                end
            end
            ST_CS_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_LAST) begin
                    cnt_d  = '0;
                    cs_n_d = 1'b1;
                    busy_d = 1'b0;
                    if (init_done_q) begin
                        state_d = ST_LATCH;
                        gx_d    = rx_q[47:32];
                        gy_d    = rx_q[31:16];
                        gz_d    = rx_q[15:0];
                        valid_d = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
                if (tick) begin
                    start_frame = 1'b1;
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    start_frame = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT_WAIT;
                cnt_d   = '0;
            end
        endcase

        // The first bit goes out together with the falling cs_n.
        if (start_frame) begin
            state_d = ST_CS_SETUP;
            cnt_d   = '0;
            bit_d   = '0;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b1;
            busy_d  = 1'b1;
            mosi_d  = frame_word[55];
            tx_d    = frame_word[54:0];
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_in) begin
            state_q     <= ST_INIT_WAIT;
            cnt_q       <= '0;
            bit_q       <= '0;
            timer_q     <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            init_done_q <= 1'b0;
            sclk_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            gz_q        <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            timer_q     <= timer_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            init_done_q <= init_done_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            gz_q        <= gz_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs_n  = cs_n_q;
    assign gx    = gx_q;
    assign gy    = gy_q;
    assign gz    = gz_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_spi_gyro_reader.sv
// Directed bench for spi_gyro_reader: SPI slave model plus a bus monitor that
// decodes MOSI bytes, counts SCLK edges and measures valid timing.
module tb_spi_gyro_reader;
    localparam int CLK_DIV       = 5;
    localparam int SAMPLE_PERIOD = 1000;
    localparam int FRAME_CYC     = 114 * CLK_DIV;

    logic        clk_100mhz = 1'b0;
    logic        rst_in     = 1'b0;
    logic        miso       = 1'b0;
    logic        sclk, mosi, cs_n, valid, busy;
    logic [15:0] gx, gy, gz;

    spi_gyro_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .GYRO_REG      (8'h43),
        .PWR_REG       (8'h6B),
        .PWR_VAL       (8'h00)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_in     (rst_in),
        .miso       (miso),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .gx         (gx),
        .gy         (gy),
        .gz         (gz),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mode-3 slave: present bit i on the i-th SCLK falling edge of the frame.
    logic [47:0] slv_data = 48'd0;
    bit          slv_ones = 1'b0;
    int          slv_fall = 0;

    always @(negedge cs_n) slv_fall = 0;

    always @(negedge sclk) begin
        if (cs_n === 1'b0) begin
            if (slv_ones)
                miso = 1'b1;
            else if (slv_fall >= 8 && slv_fall <= 55)
                miso = slv_data[55 - slv_fall];
            else
                miso = 1'b0;
            slv_fall++;
        end
    end

    // Bus monitor, sampled on the falling clk edge.
    int          cyc = 0;
    logic        sclk_p = 1'b1, cs_p = 1'b1, mosi_p = 1'b0, valid_p = 1'b0;
    logic [15:0] gx_p = '0, gy_p = '0, gz_p = '0;
    int          mosi_age = 0;
    int          edges = 0, cs_fall_cyc = 0;
    logic [7:0]  cmd_byte = '0, dat_byte = '0;
    int          n_frames = 0, f_edges = 0, f_cs_fall = 0;
    logic [7:0]  f_cmd = '0, f_dat = '0;
    int          bad_idle_sclk = 0, bad_setup = 0, bad_hold = 0;
    int          n_valid = 0, valid_run = 0, last_run = 0;
    int          valid_cyc = 0, valid_cyc_prev = 0;

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    always @(negedge clk_100mhz) begin
        if (mosi !== mosi_p) mosi_age = 0;
        else mosi_age++;
        if (cs_n === 1'b1 && sclk !== 1'b1) bad_idle_sclk++;
        if (cs_n === 1'b0 && cs_p === 1'b1) begin
            edges = 0; cmd_byte = '0; dat_byte = '0; cs_fall_cyc = cyc;
        end
        if (cs_n === 1'b0 && sclk === 1'b1 && sclk_p === 1'b0) begin
            if (mosi_age < CLK_DIV) bad_setup++;
            if (edges < 8) cmd_byte = {cmd_byte[6:0], mosi};
            else if (edges < 16) dat_byte = {dat_byte[6:0], mosi};
            edges++;
        end
        if (cs_n === 1'b1 && cs_p === 1'b0) begin
            f_edges = edges; f_cmd = cmd_byte; f_dat = dat_byte; f_cs_fall = cs_fall_cyc;
            n_frames++;
        end
        if (valid === 1'b1) begin
            valid_run++;
            if (valid_run == 1) begin
                valid_cyc_prev = valid_cyc; valid_cyc = cyc; n_valid++;
            end
        end else begin
            if (valid_run > 0) last_run = valid_run;
            valid_run = 0;
        end
        if (rst_in === 1'b1 && valid !== 1'b1 &&
            (gx !== gx_p || gy !== gy_p || gz !== gz_p)) bad_hold++;
        sclk_p = sclk; cs_p = cs_n; mosi_p = mosi; valid_p = valid;
        gx_p = gx; gy_p = gy; gz_p = gz;
    end

    task automatic tick();
        @(negedge clk_100mhz);
        #1;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int budget = 3 * SAMPLE_PERIOD;
        while (n_frames < target && budget > 0) begin tick(); budget--; end
        check(tag, n_frames, target);
    endtask

    task automatic wait_valid(input int target, input string tag);
        int budget = 3 * SAMPLE_PERIOD;
        while (n_valid < target && budget > 0) begin tick(); budget--; end
        check(tag, n_valid, target);
    endtask

    task automatic check_sample(input string tag, input logic [15:0] ex,
                                input logic [15:0] ey, input logic [15:0] ez);
        wait_valid(n_valid + 1, {tag, "_wait"});
        check({tag, "_gx"}, gx, ex);
        check({tag, "_gy"}, gy, ey);
        check({tag, "_gz"}, gz, ez);
        check({tag, "_edges"}, f_edges, 56);
        check({tag, "_addr"}, f_cmd, 8'hC3);
        check({tag, "_cs_to_valid"}, valid_cyc - f_cs_fall, FRAME_CYC);
        tick();
        tick();
        check({tag, "_valid_len"}, last_run, 1);
        $display("sample %s: addr=%02h edges=%0d gx=%04h gy=%04h gz=%04h at cyc %0d",
                 tag, f_cmd, f_edges, gx, gy, gz, valid_cyc);
    endtask

    task automatic check_init(input string tag);
        check({tag, "_edges"}, f_edges, 16);
        check({tag, "_reg"}, f_cmd, 8'h6B);
        check({tag, "_val"}, f_dat, 8'h00);
        $display("init %s: reg=%02h val=%02h edges=%0d", tag, f_cmd, f_dat, f_edges);
    endtask

    int fr0, nv0;

    initial begin
        // Reset held for 5 cycles
        rst_in = 1'b0;
        repeat (5) tick();
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_gxyz", {gx, gy}, 32'd0);
        check("rst_gz", gz, 16'd0);
        rst_in = 1'b1;
        repeat (10) tick();
        check("initwait_cs_n", cs_n, 1'b1);
        check("initwait_busy", busy, 1'b0);

        slv_data = 48'h0100_0200_F600;
        wait_frames(1, "init_frame_wait");
        check_init("first");
        check("init_no_valid", n_valid, 0);
        check("init_gx_held", gx, 16'd0);

        check_sample("decode", 16'h0100, 16'h0200, 16'hF600);

        slv_data = 48'h7FFF_8000_0001;
        check_sample("per1", 16'h7FFF, 16'h8000, 16'h0001);
        check("per1_period", valid_cyc - valid_cyc_prev, SAMPLE_PERIOD);
        slv_data = 48'h8000_0001_7FFF;
        check_sample("per2", 16'h8000, 16'h0001, 16'h7FFF);
        check("per2_period", valid_cyc - valid_cyc_prev, SAMPLE_PERIOD);
        slv_data = 48'h0001_7FFF_8000;
        check_sample("per3", 16'h0001, 16'h7FFF, 16'h8000);
        check("per3_period", valid_cyc - valid_cyc_prev, SAMPLE_PERIOD);
        check("hold_between_pulses", bad_hold, 0);

        // Mid-frame reset at the 30th SCLK rising edge of the next sample frame
        begin
            int budget = 3 * SAMPLE_PERIOD;
            while (!(cs_n === 1'b0 && edges >= 30) && budget > 0) begin tick(); budget--; end
            check("midrst_reach_edge30", (edges >= 30) ? 1 : 0, 1);
        end
        nv0 = n_valid;
        rst_in = 1'b0;
        tick();
        check("midrst_cs_n", cs_n, 1'b1);
        check("midrst_sclk", sclk, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_gxy", {gx, gy}, 32'd0);
        check("midrst_gz", gz, 16'd0);
        fr0 = n_frames;
        repeat (3) tick();
        rst_in = 1'b1;
        slv_data = 48'h1234_5678_9ABC;
        wait_frames(fr0 + 1, "midrst_init_wait");
        check_init("after_reset");
        check("midrst_no_valid", n_valid, nv0);
        check_sample("recover", 16'h1234, 16'h5678, 16'h9ABC);

        slv_ones = 1'b1;
        check_sample("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF);

        check("sclk_high_when_idle", bad_idle_sclk, 0);
        check("mosi_setup_before_rise", bad_setup, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
